// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StFin
  } dma_state_e;

  localparam int unsigned AddrStepDefault = 4;

endpackage

// File: rtl/dma_engine.sv
// Word-by-word memory copy engine: read one word, write it, advance, repeat.
module dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_STEP = AddrStepDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [31:0] transfer_size,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ack,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] words_left
);

  localparam logic [31:0] Step = 32'(ADDR_STEP);

  dma_state_e  state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] count_q, count_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          count_d = transfer_size;
          state_d = (transfer_size == 32'd0) ? StFin : StRd;
        end
      end
      StRd: begin
        if (mem_rd_ack) begin
          data_d  = mem_rd_data;
          state_d = StWr;
        end
      end
      StWr: begin
        if (mem_wr_ack) begin
          count_d = count_q - 32'd1;
          // Addresses wrap modulo 2^32 by plain unsigned overflow.
          src_d   = src_q + Step;
          dst_d   = dst_q + Step;
          state_d = (count_q > 32'd1) ? StRd : StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      count_q <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign mem_rd_req  = (state_q == StRd);
  assign mem_rd_addr = src_q;
  assign mem_wr_req  = (state_q == StWr);
  assign mem_wr_addr = dst_q;
  assign mem_wr_data = data_q;
  assign busy        = (state_q == StRd) || (state_q == StWr);
  assign done        = (state_q == StFin);
  assign words_left  = count_q;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench: job-level model of the copy engine plus directed scenarios.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0, transfer_size = '0;
  logic        mem_rd_ack = 1'b0, mem_wr_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        mem_rd_req, mem_wr_req, busy, done;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data, words_left;

  dma_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .transfer_size(transfer_size),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ack   (mem_wr_ack),
    .busy         (busy),
    .done         (done),
    .words_left   (words_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job model: a job of N words is 2N alternating handshakes (read k, write k).
  bit          m_active = 0, m_done_due = 0, m_after_rst = 0;
  int          m_h = 0;
  logic [31:0] m_src, m_dst, m_size, m_last_rd;
  int          m_start_cyc = 0;
  int          done_lat = 0;
  bit          done_seen = 0, req_seen = 0;
  int          served_h = -1, wait_cnt = 0;
  int          wait_mode = 0;
  bit          spurious = 0;
  logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];

  function automatic int pick(bit is_wr);
    case (wait_mode)
      0:       return 0;
      1:       return is_wr ? 0 : 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] k;
    bit hs;
    k = 32'(m_h / 2);
    check("done", {31'd0, done}, {31'd0, m_done_due});
    check("busy", {31'd0, busy}, {31'd0, m_active});
    check("words_left", words_left, (m_active || m_done_due) ? m_size - k : 32'd0);
    if (m_active) begin
      check("rd_req", {31'd0, mem_rd_req}, {31'd0, ~m_h[0]});
      check("wr_req", {31'd0, mem_wr_req}, {31'd0, m_h[0]});
      if (!m_h[0]) check("rd_addr", mem_rd_addr, m_src + k * 32'd4);
      else begin
        check("wr_addr", mem_wr_addr, m_dst + k * 32'd4);
        check("wr_data", mem_wr_data, m_last_rd);
      end
    end else begin
      check("rd_req_idle", {31'd0, mem_rd_req}, 32'd0);
      check("wr_req_idle", {31'd0, mem_wr_req}, 32'd0);
    end
    if (m_after_rst) begin
      check("rst_rd_addr", mem_rd_addr, 32'd0);
      check("rst_wr_addr", mem_wr_addr, 32'd0);
      check("rst_wr_data", mem_wr_data, 32'd0);
    end
    if (mem_rd_req || mem_wr_req) req_seen = 1;
    if (done) begin
      done_seen = 1;
      done_lat = cyc - m_start_cyc;
    end

    // Memory responder
    mem_rd_data = $urandom;
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    if (m_active) begin
      if (m_h != served_h) begin
        served_h = m_h;
        wait_cnt = pick(m_h[0]);
      end
      if (wait_cnt == 0) begin
        if (m_h[0]) mem_wr_ack = 1'b1;
        else mem_rd_ack = 1'b1;
      end else wait_cnt--;
      if (spurious) begin
        if (m_h[0]) mem_rd_ack = 1'($urandom_range(0, 1));
        else mem_wr_ack = 1'($urandom_range(0, 1));
      end
    end else if (spurious) begin
      mem_rd_ack = 1'($urandom_range(0, 1));
      mem_wr_ack = 1'($urandom_range(0, 1));
    end
    hs = m_active && (m_h[0] ? mem_wr_ack : mem_rd_ack);

    // Advance model to the next cycle
    if (rst) begin
      m_active = 0;
      m_done_due = 0;
      m_h = 0;
      served_h = -1;
    end else if (m_done_due) begin
      m_done_due = 0;
    end else if (m_active) begin
      if (hs) begin
        if (!m_h[0]) begin
          m_last_rd = mem_rd_data;
          rd_log.push_back(mem_rd_addr);
        end else begin
          wr_addr_log.push_back(mem_wr_addr);
          wr_data_log.push_back(mem_wr_data);
        end
        m_h++;
        if (m_h == 2 * int'(m_size)) begin
          m_active = 0;
          m_done_due = 1;
        end
      end
    end else if (start) begin
      m_src = src_addr;
      m_dst = dst_addr;
      m_size = transfer_size;
      m_h = 0;
      served_h = -1;
      m_start_cyc = cyc;
      if (transfer_size == 32'd0) m_done_due = 1;
      else m_active = 1;
    end
    m_after_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    req_seen = 0;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    clear_logs();
    done_seen = 0;
    src_addr = s;
    dst_addr = d;
    transfer_size = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300 && !done_seen; i++) tick();
    check({name, "_completed"}, {31'd0, done_seen}, 32'd1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Zero-wait three-word copy
    wait_mode = 0;
    launch(32'h1000, 32'h2000, 32'd3);
    wait_done("basic");
    check("basic_lat", 32'(done_lat), 32'd7);
    check("basic_nrd", 32'(rd_log.size()), 32'd3);
    check("basic_nwr", 32'(wr_addr_log.size()), 32'd3);
    if (rd_log.size() == 3 && wr_addr_log.size() == 3) begin
      check("basic_rd2", rd_log[2], 32'h1008);
      check("basic_wr1", wr_addr_log[1], 32'h2004);
      check("basic_wr2", wr_addr_log[2], 32'h2008);
    end

    // Zero-length job
    launch(32'h1000, 32'h2000, 32'd0);
    wait_done("zero");
    check("zero_lat", 32'(done_lat), 32'd1);
    check("zero_noreq", {31'd0, req_seen}, 32'd0);

    // Slow reads: three wait cycles each
    wait_mode = 1;
    launch(32'h3000, 32'h4000, 32'd2);
    wait_done("slow");
    check("slow_lat", 32'(done_lat), 32'd11);
    check("slow_nwr", 32'(wr_addr_log.size()), 32'd2);
    wait_mode = 0;

    // Address wrap
    launch(32'hFFFF_FFFC, 32'h10, 32'd2);
    wait_done("wrap");
    check("wrap_nrd", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) check("wrap_rd1", rd_log[1], 32'h0);

    // Start pulsed during a write is ignored
    launch(32'h5000, 32'h6000, 32'd4);
    tick();
    check("ign_in_wr", {31'd0, mem_wr_req}, 32'd1);
    src_addr = 32'h9000;
    dst_addr = 32'h9800;
    transfer_size = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore");
    check("ign_lat", 32'(done_lat), 32'd9);
    check("ign_nwr", 32'(wr_addr_log.size()), 32'd4);
    if (wr_addr_log.size() == 4) check("ign_wr3", wr_addr_log[3], 32'h600C);

    // Reset while a write is pending
    launch(32'h7000, 32'h8000, 32'd4);
    tick();
    check("rst_in_wr", {31'd0, mem_wr_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
    check("rst_words", words_left, 32'd0);
    check("rst_wdata", mem_wr_data, 32'd0);
    launch(32'h100, 32'h200, 32'd1);
    wait_done("after_rst");
    check("after_rst_lat", 32'(done_lat), 32'd3);
    if (wr_addr_log.size() == 1) check("after_rst_wr0", wr_addr_log[0], 32'h200);
    else check("after_rst_nwr", 32'(wr_addr_log.size()), 32'd1);

    // Randomized traffic with spurious acks, stray starts and rare resets
    spurious = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) wait_mode = int'($urandom_range(0, 2));
      rst = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      src_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4
                                             : ($urandom & 32'hFFFF_FFFC);
      dst_addr = $urandom & 32'hFFFF_FFFC;
      transfer_size = 32'($urandom_range(0, 5));
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 200 && (m_active || m_done_due); i++) tick();
    check("drain_idle", {31'd0, m_active || m_done_due}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
